freq_meter: RTL and testbench

FREQ_METER -- requirements
Module: freq_meter

---
 rtl/freq_meter.sv | 97 +++++++++
 tb/tb_freq_meter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
// Gated event counter: counts tick_in strobes while gate_in is high and
// presents each completed window's count on a valid/ready result port.
module freq_meter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             gate_in,
  input  logic             tick_in,
  output logic [CNT_W-1:0] cnt_out,
  output logic             cnt_ovf,
  output logic             cnt_valid,
  input  logic             cnt_ready,
  output logic             overrun,
  output logic             busy
);

  typedef enum logic {
    ARM   = 1'b0,
    COUNT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic             gate_q;
  logic [CNT_W-1:0] counter;
  logic             sat;

  logic rise_c;
  logic fall_c;
  logic result_evt_c;
  logic xfer_c;

  // Window edge detection and result handshake decode
  always_comb begin
    rise_c       = gate_in & ~gate_q;
    fall_c       = ~gate_in & gate_q;
    result_evt_c = (state == COUNT) & fall_c;
    xfer_c       = cnt_valid & cnt_ready;
  end

  // gate_q resets high so a gate already open at reset release is not a rise
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ARM;
      gate_q    <= 1'b1;
      counter   <= '0;
      sat       <= 1'b0;
      cnt_out   <= '0;
      cnt_ovf   <= 1'b0;
      cnt_valid <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      gate_q <= gate_in;

      unique case (state)
        ARM: begin
          if (rise_c) begin
            state   <= COUNT;
            busy    <= 1'b1;
            counter <= CNT_W'(tick_in);
            sat     <= 1'b0;
          end
        end
        COUNT: begin
          if (fall_c) begin
            state   <= ARM;
            busy    <= 1'b0;
            sat     <= 1'b0;
            cnt_out <= counter;
            cnt_ovf <= sat;
          end else if (gate_in && tick_in) begin
            // Saturate instead of wrapping; excess ticks only flag overflow
            if (counter == CNT_MAX) begin
              sat <= 1'b1;
            end else begin
              counter <= counter + CNT_W'(1);
            end
          end
        end
      endcase

      // A new result always wins; overwriting an unconsumed one is sticky
      if (result_evt_c) begin
        cnt_valid <= 1'b1;
        if (cnt_valid && !cnt_ready) begin
          overrun <= 1'b1;
        end
      end else if (xfer_c) begin
        cnt_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: stimulus queues expected results, a monitor
// pops and compares them on every result transfer.
module tb_freq_meter;

  localparam int unsigned W = 4;

  typedef struct {
    logic [W-1:0] cnt;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         gate_in;
  logic         tick_in;
  logic [W-1:0] cnt_out;
  logic         cnt_ovf;
  logic         cnt_valid;
  logic         cnt_ready;
  logic         overrun;
  logic         busy;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  freq_meter #(.CNT_W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .gate_in   (gate_in),
    .tick_in   (tick_in),
    .cnt_out   (cnt_out),
    .cnt_ovf   (cnt_ovf),
    .cnt_valid (cnt_valid),
    .cnt_ready (cnt_ready),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int cnt, input bit ovf);
    exp_t e;
    e.cnt = W'(cnt);
    e.ovf = ovf;
    exp_q.push_back(e);
  endtask

  // Hold gate high for len cycles; tick on every period-th cycle from the rise
  task automatic open_window(input int len, input int period);
    for (int i = 0; i < len; i++) begin
      gate_in = 1'b1;
      tick_in = (period != 0 && (i % period) == 0) ? 1'b1 : 1'b0;
      step();
    end
  endtask

  // Fall cycle carries a tick that must be ignored
  task automatic close_window();
    gate_in = 1'b0;
    tick_in = 1'b1;
    step();
    tick_in = 1'b0;
  endtask

  task automatic run_window(input int len, input int period, input int cnt, input bit ovf);
    push(cnt, ovf);
    open_window(len, period);
    close_window();
  endtask

  // Scoreboard monitor: a transfer happens on the next edge
  always @(negedge clk) begin
    if (reset && cnt_valid && cnt_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got cnt=%0d ovf=%0d required no result", cnt_out, cnt_ovf);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_cnt_out", int'(cnt_out), int'(e.cnt));
        chk("sb_cnt_ovf", int'(cnt_ovf), int'(e.ovf));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    gate_in   = 1'b1;
    tick_in   = 1'b1;
    cnt_ready = 1'b1;
    #1 reset = 1'b0;
    repeat (3) step();
    chk("rst_cnt_out", int'(cnt_out), 0);
    chk("rst_cnt_ovf", int'(cnt_ovf), 0);
    chk("rst_valid", int'(cnt_valid), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_busy", int'(busy), 0);

    // Gate already high at reset release must not open a window
    reset = 1'b1;
    repeat (10) step();
    chk("gate_hi_rel_busy", int'(busy), 0);
    gate_in = 1'b0;
    tick_in = 1'b0;
    repeat (3) step();
    chk("gate_hi_rel_valid", int'(cnt_valid), 0);
    run_window(5, 1, 5, 1'b0);
    step();

    // 12 ticks with latency and one-cycle valid checks
    push(12, 1'b0);
    open_window(12, 1);
    chk("w12_busy", int'(busy), 1);
    chk("w12_valid_pre", int'(cnt_valid), 0);
    close_window();
    chk("w12_valid_lat", int'(cnt_valid), 1);
    chk("w12_busy_post", int'(busy), 0);
    step();
    chk("w12_valid_drop", int'(cnt_valid), 0);

    run_window(30, 5, 6, 1'b0);
    run_window(20, 1, 15, 1'b1);
    run_window(3, 1, 3, 1'b0);
    run_window(15, 1, 15, 1'b0);
    run_window(16, 1, 15, 1'b1);
    run_window(1, 1, 1, 1'b0);
    run_window(1, 0, 0, 1'b0);
    step();

    // Overwrite of unconsumed result sets sticky overrun
    cnt_ready = 1'b0;
    open_window(4, 1);
    close_window();
    open_window(7, 1);
    close_window();
    chk("ovr_cnt_out", int'(cnt_out), 7);
    chk("ovr_valid", int'(cnt_valid), 1);
    chk("ovr_overrun", int'(overrun), 1);
    push(7, 1'b0);
    push(2, 1'b0);
    open_window(2, 1);
    gate_in   = 1'b0;
    tick_in   = 1'b0;
    cnt_ready = 1'b1;
    step();
    chk("simul_valid", int'(cnt_valid), 1);
    chk("simul_overrun", int'(overrun), 1);
    chk("simul_cnt_out", int'(cnt_out), 2);
    step();
    chk("simul_valid_drop", int'(cnt_valid), 0);
    chk("overrun_sticky", int'(overrun), 1);

    // Reset mid-window discards the partial count
    open_window(8, 1);
    reset = 1'b0;
    #1;
    chk("midrst_cnt_out", int'(cnt_out), 0);
    chk("midrst_valid", int'(cnt_valid), 0);
    chk("midrst_overrun", int'(overrun), 0);
    chk("midrst_busy", int'(busy), 0);
    repeat (2) step();
    reset = 1'b1;
    repeat (3) step();
    gate_in = 1'b0;
    tick_in = 1'b0;
    repeat (2) step();
    chk("midrst_no_result", int'(cnt_valid), 0);
    run_window(3, 1, 3, 1'b0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    chk("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
